// File: rtl/regfile_multiport.sv
// Parametrised multi-read-port integer register file with x0 hardwired to zero
// and a sequenced post-reset clear. Optional write-to-read bypass: REGFILE_BYPASS_EN.
//
// Ports:
//   clk            in   clock, all state on rising edge
//   reset          in   synchronous, active-high
//   readRegister   in   NUM_READ*ADDR_W packed read addresses (port p at [p*ADDR_W +: ADDR_W])
//   readData       out  NUM_READ*DATA_W packed read data (port p at [p*DATA_W +: DATA_W])
//   writeRegister  in   ADDR_W write address
//   writeData      in   DATA_W write data
//   regWrite       in   write enable
//   ready          out  high once every entry has been cleared
module regfile_multiport #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_READ*ADDR_W-1:0] readRegister,
  output logic [NUM_READ*DATA_W-1:0] readData,
  input  logic [ADDR_W-1:0]          writeRegister,
  input  logic [DATA_W-1:0]          writeData,
  input  logic                       regWrite,
  output logic                       ready
);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic clr_we;
  logic wr_req;
  logic wr_commit;

  // Nonzero and inside the array; DEPTH need not be a power of two.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a != '0) && (int'(a) < DEPTH);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    clr_we    = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        clr_we = 1'b1;
        if (clr_idx_q == LAST) begin
          state_d = S_READY;
          ready_d = 1'b1;
        end else begin
          clr_idx_d = clr_idx_q + ADDR_W'(1);
        end
      end
      S_READY: begin
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase
  end

  assign wr_req    = regWrite && ready_q && addr_ok(writeRegister);
  assign wr_commit = wr_req && !reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clr_we) begin
        mem_q[clr_idx_q] <= '0;
      end else if (wr_commit) begin
        mem_q[writeRegister] <= writeData;
      end
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = readRegister[p*ADDR_W +: ADDR_W];

    always_comb begin
      rd = '0;
      if (ready_q && addr_ok(ra)) begin
`ifdef REGFILE_BYPASS_EN
        if (wr_req && (ra == writeRegister)) begin
          rd = writeData;
        end else begin
          rd = mem_q[ra];
        end
`else
        rd = mem_q[ra];
`endif
      end
    end

    assign readData[p*DATA_W +: DATA_W] = rd;
  end

  assign ready = ready_q;

endmodule
